// File: rtl/ctrl_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_seq_pkg
//  Description : Shared types for the control sequencer: opcode and state
//                encodings, the datapath control-word layout and a small
//                helper used by the sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package ctrl_seq_pkg;

  // Width of the encoded opcode set below; the decoder adapts OP_W to this.
  localparam int c_OPC_W = 4;

  typedef enum logic [c_OPC_W-1:0] {
    NOP = 4'h0,
    LDA = 4'h1,
    LDB = 4'h2,
    ADD = 4'h3,
    SUB = 4'h4,
    JMP = 4'h5,
    JC  = 4'h6,
    JZ  = 4'h7,
    HLT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    WAIT  = 2'd2,
    HALT  = 2'd3
  } state_e;

  typedef struct packed {
    logic load_a;
    logic load_b;
    logic en_a;
    logic en_b;
    logic add;
    logic sub;
    logic fi;
  } ctrl_word_t;

  localparam ctrl_word_t c_CTRL_IDLE = '0;

  // True when the control word writes one of the A/B registers from imm_out.
  function automatic logic ctrl_is_load(input ctrl_word_t c);
    return c.load_a | c.load_b;
  endfunction

endpackage : ctrl_seq_pkg
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_decode
//  Description : Purely combinational opcode decoder. Maps an opcode plus the
//                ALU flags to the datapath control word and the sequencing
//                hints (jump taken, halt, ALU op needing a settle cycle).
//  Ports       :
//    i_opc         in   OP_W   opcode field of the instruction
//    i_carry       in   1      ALU carry flag
//    i_zero        in   1      ALU zero flag
//    o_ctrl        out  ctrl_word_t  strobes for this instruction
//    o_jump_taken  out  1      pc is to be loaded from the operand
//    o_is_halt     out  1      instruction is HLT
//    o_is_alu      out  1      instruction is ADD/SUB (needs a WAIT cycle)
//  Revision    : 1.0  initial release
// ============================================================================
module ctrl_decode
  import ctrl_seq_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic [OP_W-1:0] i_opc,
  input  logic            i_carry,
  input  logic            i_zero,
  output ctrl_word_t      o_ctrl,
  output logic            o_jump_taken,
  output logic            o_is_halt,
  output logic            o_is_alu
);

  logic [c_OPC_W-1:0] w_opc_raw;
  opcode_e            w_opc;

  // Fit the configured opcode field onto the fixed opcode encoding.
  generate
    if (OP_W >= c_OPC_W) begin : g_opc_fit
      assign w_opc_raw = i_opc[c_OPC_W-1:0];
    end else begin : g_opc_ext
      assign w_opc_raw = {{(c_OPC_W-OP_W){1'b0}}, i_opc};
    end
  endgenerate

  assign w_opc = opcode_e'(w_opc_raw);

  always_comb begin
    o_ctrl       = c_CTRL_IDLE;
    o_jump_taken = 1'b0;
    o_is_halt    = 1'b0;
    o_is_alu     = 1'b0;
    case (w_opc)
      LDA: o_ctrl.load_a = 1'b1;
      LDB: o_ctrl.load_b = 1'b1;
      ADD: begin
        o_ctrl.en_a = 1'b1;
        o_ctrl.en_b = 1'b1;
        o_ctrl.add  = 1'b1;
        o_ctrl.fi   = 1'b1;
        o_is_alu    = 1'b1;
      end
      SUB: begin
        o_ctrl.en_a = 1'b1;
        o_ctrl.en_b = 1'b1;
        o_ctrl.sub  = 1'b1;
        o_ctrl.fi   = 1'b1;
        o_is_alu    = 1'b1;
      end
      JMP: o_jump_taken = 1'b1;
      JC:  o_jump_taken = i_carry;
      JZ:  o_jump_taken = i_zero;
      HLT: o_is_halt    = 1'b1;
      // NOP and every unassigned opcode execute as NOP.
      default: ;
    endcase
  end

endmodule : ctrl_decode
`default_nettype wire

// File: rtl/ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_seq
//  Description : Control sequencer for the A/B register + ALU datapath.
//                Fetches 8-bit instructions over a valid/ready handshake,
//                drives registered datapath strobes, the immediate bus and
//                the program counter, and branches on the ALU flags.
//  Configuration macro : CTRL_SEQ_RETIRE_CNT_EN
//                defined   -> adds 16-bit saturating retired-instruction count
//                undefined -> no counter, no port
//  Ports       :
//    clk          in   1       system clock, rising edge
//    rst          in   1       asynchronous reset, active-high
//    instr        in   DATA_W  instruction word {opcode, operand}
//    instr_valid  in   1       instr is valid
//    instr_ready  out  1       sequencer accepts instr (FETCH only)
//    pc           out  PC_W    fetch address
//    carry/zero   in   1       ALU flags, sampled during EXEC
//    load_a/b     out  1       load A/B from imm_out
//    en_a/b       out  1       A/B output enables
//    add/sub/fi   out  1       ALU strobes
//    imm_out      out  DATA_W  zero-extended operand during LDA/LDB
//    halted       out  1       sequencer in HALT
//    retired      out  16      (macro only) executed-instruction count
//  Revision    : 1.0  initial release
// ============================================================================
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int PC_W   = 4,
  parameter int DATA_W = 8,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [PC_W-1:0]   pc,
  input  logic              carry,
  input  logic              zero,
  output logic              load_a,
  output logic              load_b,
  output logic              en_a,
  output logic              en_b,
  output logic              add,
  output logic              sub,
  output logic              fi,
  output logic [DATA_W-1:0] imm_out,
  output logic              halted
`ifdef CTRL_SEQ_RETIRE_CNT_EN
  ,
  output logic [15:0]       retired
`endif
);

  localparam int OPND_W = DATA_W - OP_W;

  // Registered state
  state_e            r_state;
  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_ir;
  ctrl_word_t        r_ctrl;
  logic [DATA_W-1:0] r_imm;
  logic              r_ready;
  logic              r_halted;

  // Next-state values
  state_e            w_state_nxt;
  logic [PC_W-1:0]   w_pc_nxt;
  logic [DATA_W-1:0] w_ir_nxt;
  ctrl_word_t        w_ctrl_nxt;
  logic [DATA_W-1:0] w_imm_nxt;

  // Decoder interface
  logic [OP_W-1:0]   w_dec_opc;
  ctrl_word_t        w_dec_ctrl;
  logic              w_dec_jump;
  logic              w_dec_halt;
  logic              w_dec_alu;

  logic              w_accept;
  logic [DATA_W-1:0] w_imm_ext;
  logic [OPND_W-1:0] w_opnd;
  logic [PC_W-1:0]   w_jmp_pc;
  logic [PC_W-1:0]   w_pc_inc;

  // Strobes are registered, so for them to be visible during EXEC they are
  // decoded from the incoming word at the accept edge. Jump/halt/ALU hints
  // are taken from IR during EXEC, when the live flags are the ones to use.
  assign w_dec_opc = (r_state == FETCH) ? instr[DATA_W-1 -: OP_W]
                                        : r_ir[DATA_W-1 -: OP_W];

  ctrl_decode #(
    .OP_W (OP_W)
  ) u_decode (
    .i_opc        (w_dec_opc),
    .i_carry      (carry),
    .i_zero       (zero),
    .o_ctrl       (w_dec_ctrl),
    .o_jump_taken (w_dec_jump),
    .o_is_halt    (w_dec_halt),
    .o_is_alu     (w_dec_alu)
  );

  assign w_accept  = instr_valid & r_ready;
  assign w_imm_ext = {{OP_W{1'b0}}, instr[OPND_W-1:0]};
  assign w_opnd    = r_ir[OPND_W-1:0];
  assign w_pc_inc  = r_pc + {{(PC_W-1){1'b0}}, 1'b1};

  // Jump target: operand truncated or zero-extended to the pc width.
  generate
    if (PC_W <= OPND_W) begin : g_jmp_trunc
      assign w_jmp_pc = w_opnd[PC_W-1:0];
    end else begin : g_jmp_ext
      assign w_jmp_pc = {{(PC_W-OPND_W){1'b0}}, w_opnd};
    end
  endgenerate

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_ctrl_nxt  = c_CTRL_IDLE;
    w_imm_nxt   = '0;
    case (r_state)
      FETCH: begin
        if (w_accept) begin
          w_ir_nxt    = instr;
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = EXEC;
          w_ctrl_nxt  = w_dec_ctrl;
          if (ctrl_is_load(w_dec_ctrl)) begin
            w_imm_nxt = w_imm_ext;
          end
        end
      end
      EXEC: begin
        if (w_dec_halt) begin
          w_state_nxt = HALT;
        end else if (w_dec_alu) begin
          w_state_nxt = WAIT;
        end else begin
          w_state_nxt = FETCH;
        end
        if (w_dec_jump) begin
          w_pc_nxt = w_jmp_pc;
        end
      end
      WAIT:    w_state_nxt = FETCH;
      HALT:    w_state_nxt = HALT;
      default: w_state_nxt = FETCH;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= FETCH;
      r_pc     <= '0;
      r_ir     <= '0;
      r_ctrl   <= c_CTRL_IDLE;
      r_imm    <= '0;
      r_ready  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_ir     <= w_ir_nxt;
      r_ctrl   <= w_ctrl_nxt;
      r_imm    <= w_imm_nxt;
      // Ready/halted are registered so they are low throughout reset and
      // track the state they describe exactly.
      r_ready  <= (w_state_nxt == FETCH);
      r_halted <= (w_state_nxt == HALT);
    end
  end

  assign instr_ready = r_ready;
  assign pc          = r_pc;
  assign load_a      = r_ctrl.load_a;
  assign load_b      = r_ctrl.load_b;
  assign en_a        = r_ctrl.en_a;
  assign en_b        = r_ctrl.en_b;
  assign add         = r_ctrl.add;
  assign sub         = r_ctrl.sub;
  assign fi          = r_ctrl.fi;
  assign imm_out     = r_imm;
  assign halted      = r_halted;

`ifdef CTRL_SEQ_RETIRE_CNT_EN
  // One count per EXEC cycle (HLT included), saturating at all-ones.
  logic [15:0] r_retired;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retired <= '0;
    end else if ((r_state == EXEC) && (r_retired != 16'hFFFF)) begin
      r_retired <= r_retired + 16'd1;
    end
  end

  assign retired = r_retired;
`else
  // Retired-instruction counter not built.
`endif

endmodule : ctrl_seq
`default_nettype wire

// File: tb/tb_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctrl_seq
//  Description : Self-checking bench for ctrl_seq. Each accepted instruction
//                pushes its expected EXEC-cycle strobes and pc values to a
//                queue; the scenario tasks pop and compare them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] instr = 8'h00;
  logic       instr_valid = 1'b0;
  logic       carry = 1'b0;
  logic       zero = 1'b0;
  logic       instr_ready;
  logic [3:0] pc;
  logic       load_a, load_b, en_a, en_b, add, sub, fi, halted;
  logic [7:0] imm_out;
`ifdef CTRL_SEQ_RETIRE_CNT_EN
  logic [15:0] retired;
`endif

  ctrl_seq u_dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .carry       (carry),
    .zero        (zero),
    .load_a      (load_a),
    .load_b      (load_b),
    .en_a        (en_a),
    .en_b        (en_b),
    .add         (add),
    .sub         (sub),
    .fi          (fi),
    .imm_out     (imm_out),
    .halted      (halted)
`ifdef CTRL_SEQ_RETIRE_CNT_EN
    ,
    .retired     (retired)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] ctrl;      // {load_a,load_b,en_a,en_b,add,sub,fi}
    logic [7:0] imm;
    logic [3:0] pc_exec;   // pc during EXEC
    logic [3:0] pc_after;  // pc once EXEC completes
    logic       alu;
  } exp_t;

  exp_t       sb_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] m_pc    = 4'h0;

  wire [14:0] obs = {load_a, load_b, en_a, en_b, add, sub, fi, imm_out};

  // Reference behaviour of one instruction.
  function automatic exp_t model(input logic [7:0] ins, input logic [3:0] pc_now,
                                 input logic c, input logic z);
    exp_t       e;
    logic [3:0] op  = ins[7:4];
    logic [3:0] opd = ins[3:0];
    e          = '0;
    e.pc_exec  = pc_now + 4'd1;
    e.pc_after = e.pc_exec;
    case (op)
      4'h1: begin e.ctrl = 7'b1000000; e.imm = {4'h0, opd}; end
      4'h2: begin e.ctrl = 7'b0100000; e.imm = {4'h0, opd}; end
      4'h3: begin e.ctrl = 7'b0011101; e.alu = 1'b1; end
      4'h4: begin e.ctrl = 7'b0011011; e.alu = 1'b1; end
      4'h5: e.pc_after = opd;
      4'h6: if (c) e.pc_after = opd;
      4'h7: if (z) e.pc_after = opd;
      default: ;
    endcase
    return e;
  endfunction

  // Offer one instruction, wait (bounded) for acceptance, leave the bench
  // 1 time unit into the EXEC cycle.
  task automatic send(input logic [7:0] ins);
    int   n = 0;
    exp_t e;
    instr       = ins;
    instr_valid = 1'b1;
    while (instr_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: instr %h never accepted, instr_ready=%b required 1", ins, instr_ready);
    end
    e = model(ins, m_pc, carry, zero);
    sb_q.push_back(e);
    m_pc = e.pc_after;
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    @(posedge clk); #1;
    n_tests++;
    if ({obs, pc, instr_ready, halted} !== 21'h0) begin
      n_fail++;
      $display("FAIL reset_state: got %h required 0", {obs, pc, instr_ready, halted});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (instr_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_rise: got %b required 1", instr_ready);
    end
    // ADD interrupted by reset during EXEC
    send(8'h33);
    e = sb_q.pop_front();
    n_tests++;
    if (obs !== {e.ctrl, e.imm}) begin
      n_fail++; $display("FAIL reset_add_exec: got %h required %h", obs, {e.ctrl, e.imm});
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({obs, pc, instr_ready, halted} !== 21'h0) begin
      n_fail++; $display("FAIL reset_mid_exec: got %h required 0", {obs, pc, instr_ready, halted});
    end
    @(posedge clk); #1;
    n_tests++;
    if ({obs, pc, instr_ready, halted} !== 21'h0) begin
      n_fail++; $display("FAIL reset_hold: got %h required 0", {obs, pc, instr_ready, halted});
    end
    rst  = 1'b0;
    m_pc = 4'h0;
    @(posedge clk); #1;
    n_tests++;
    if (instr_ready !== 1'b1 || pc !== 4'h0) begin
      n_fail++; $display("FAIL reset_release: ready=%b pc=%h required 1/0", instr_ready, pc);
    end
  endtask

  task automatic test_program();
    logic [7:0] prog [3] = '{8'h13, 8'h25, 8'h30};
    exp_t       e;
    for (int i = 0; i < 3; i++) begin
      send(prog[i]);
      e = sb_q.pop_front();
      n_tests++;
      if (obs !== {e.ctrl, e.imm} || pc !== e.pc_exec) begin
        n_fail++;
        $display("FAIL prog_exec[%0d]: strobes/imm=%h pc=%h required %h pc=%h", i, obs, pc, {e.ctrl, e.imm}, e.pc_exec);
      end
      @(posedge clk); #1;
      if (e.alu) begin
        n_tests++;
        if (obs !== 15'h0 || instr_ready !== 1'b0) begin
          n_fail++; $display("FAIL prog_wait[%0d]: strobes=%h ready=%b required 0/0", i, obs, instr_ready);
        end
        @(posedge clk); #1;
      end
      n_tests++;
      if (instr_ready !== 1'b1 || pc !== e.pc_after) begin
        n_fail++;
        $display("FAIL prog_latency[%0d]: ready=%b pc=%h required 1 pc=%h", i, instr_ready, pc, e.pc_after);
      end
    end
    n_tests++;
    if (pc !== 4'd3) begin
      n_fail++; $display("FAIL prog_pc3: pc=%h required 3", pc);
    end
  endtask

  task automatic test_jumps();
    // {instr, carry, zero}
    logic [9:0] tbl [5] = '{{8'h7A, 1'b0, 1'b1}, {8'h7A, 1'b0, 1'b0},
                             {8'h6C, 1'b1, 1'b0}, {8'h6C, 1'b0, 1'b1},
                             {8'h53, 1'b0, 1'b0}};
    exp_t       e;
    for (int i = 0; i < 5; i++) begin
      carry = tbl[i][1];
      zero  = tbl[i][0];
      send(tbl[i][9:2]);
      e = sb_q.pop_front();
      n_tests++;
      if (obs !== 15'h0) begin
        n_fail++; $display("FAIL jump_strobes[%0d]: got %h required 0", i, obs);
      end
      @(posedge clk); #1;
      n_tests++;
      if (pc !== e.pc_after || instr_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL jump_pc[%0d]: pc=%h ready=%b required pc=%h ready=1", i, pc, instr_ready, e.pc_after);
      end
    end
    carry = 1'b0;
    zero  = 1'b0;
  endtask

  task automatic test_backpressure_wrap();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (instr_ready !== 1'b1 || pc !== m_pc) begin
        n_fail++; $display("FAIL bp_idle[%0d]: ready=%b pc=%h required 1 pc=%h", i, instr_ready, pc, m_pc);
      end
    end
    send(8'h5F);
    e = sb_q.pop_front();
    @(posedge clk); #1;
    n_tests++;
    if (pc !== 4'hF) begin
      n_fail++; $display("FAIL wrap_setup: pc=%h required f", pc);
    end
    send(8'h00);
    e = sb_q.pop_front();
    n_tests++;
    if (pc !== e.pc_exec || pc !== 4'h0) begin
      n_fail++; $display("FAIL wrap_pc: pc=%h required 0", pc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_halt();
    exp_t       e;
    logic [3:0] p;
    send(8'hF0);
    e = sb_q.pop_front();
    p = e.pc_after;
    @(posedge clk); #1;
    n_tests++;
    if (halted !== 1'b1) begin
      n_fail++; $display("FAIL halt_enter: halted=%b required 1", halted);
    end
    instr       = 8'h13;
    instr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      n_tests++;
      if (instr_ready !== 1'b0 || halted !== 1'b1 || obs !== 15'h0 || pc !== p) begin
        n_fail++;
        $display("FAIL halt_hold[%0d]: ready=%b halted=%b strobes=%h pc=%h required 0/1/0/%h", i, instr_ready, halted, obs, pc, p);
      end
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_tests++;
    if (halted !== 1'b0 || pc !== 4'h0) begin
      n_fail++; $display("FAIL halt_reset: halted=%b pc=%h required 0/0", halted, pc);
    end
    @(posedge clk); #1;
    rst  = 1'b0;
    m_pc = 4'h0;
    @(posedge clk); #1;
    n_tests++;
    if (instr_ready !== 1'b1) begin
      n_fail++; $display("FAIL halt_release: ready=%b required 1", instr_ready);
    end
  endtask

`ifdef CTRL_SEQ_RETIRE_CNT_EN
  task automatic test_retire();
    logic [7:0] prog [5] = '{8'h00, 8'h11, 8'h52, 8'h30, 8'hF0};
    exp_t       e;
    n_tests++;
    if (retired !== 16'd0) begin
      n_fail++; $display("FAIL retire_reset: retired=%0d required 0", retired);
    end
    for (int i = 0; i < 5; i++) begin
      send(prog[i]);
      e = sb_q.pop_front();
      @(posedge clk); #1;
      if (e.alu) begin
        @(posedge clk); #1;
      end
    end
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (retired !== 16'd5) begin
        n_fail++; $display("FAIL retire_count[%0d]: retired=%0d required 5", i, retired);
      end
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_program();
    test_jumps();
    test_backpressure_wrap();
    test_halt();
`ifdef CTRL_SEQ_RETIRE_CNT_EN
    test_retire();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop in case a scenario stalls outside its own bounds.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

endmodule : tb_ctrl_seq
`default_nettype wire
